// File: rtl/rff_serial_deser.sv
// Serial-to-parallel deserializer with a single held output word and
// valid/ready handshakes on both the serial input and the parallel output.
module rff_serial_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             sin_i,
  input  logic             sin_valid_i,
  output logic             sin_ready_o,
  output logic [WIDTH-1:0] pdata_o,
  output logic             pvalid_o,
  input  logic             pready_i,
  output logic [CW-1:0]    bitcnt_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   pdata_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               pvalid_q;
  logic               last, accept, word_done;

  assign last        = (cnt_q == CW'(WIDTH-1));
  // Only the final bit of a word stalls while a previous word is still held.
  assign sin_ready_o = !(pvalid_q && !pready_i && last);
  assign accept      = sin_valid_i && sin_ready_o && !clr_i;
  assign word_done   = accept && last;

  if (MSB_FIRST) begin : g_msb
    assign shift_d = {shift_q[WIDTH-2:0], sin_i};
  end else begin : g_lsb
    assign shift_d = {sin_i, shift_q[WIDTH-1:1]};
  end

  assign cnt_d = last ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= EMPTY;
      shift_q  <= '0;
      cnt_q    <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
    end else begin
      if (clr_i) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (accept) begin
        shift_q <= shift_d;
        cnt_q   <= cnt_d;
      end

      case (state_q)
        EMPTY: begin
          if (word_done) begin
            state_q  <= FULL;
            pdata_q  <= shift_d;
            pvalid_q <= 1'b1;
          end
        end
        FULL: begin
          // A completing word replaces the held one in the same cycle it drains.
          if (word_done) begin
            pdata_q <= shift_d;
          end else if (pready_i) begin
            state_q  <= EMPTY;
            pvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= EMPTY;
          pvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pdata_o  = pdata_q;
  assign pvalid_o = pvalid_q;
  assign bitcnt_o = cnt_q;

endmodule

// File: tb/tb_rff_serial_deser.sv
// Directed bench: one MSB-first and one LSB-first instance share all inputs.
module tb_rff_serial_deser;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       clr_i = 1'b0;
  logic       sin_i = 1'b0;
  logic       sin_valid_i = 1'b0;
  logic       pready_i = 1'b0;

  logic       m_sin_ready, l_sin_ready;
  logic [7:0] m_pdata, l_pdata;
  logic       m_pvalid, l_pvalid;
  logic [2:0] m_bitcnt, l_bitcnt;

  int n_cmp = 0;
  int n_err = 0;

  rff_serial_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .sin_i(sin_i),
    .sin_valid_i(sin_valid_i), .sin_ready_o(m_sin_ready), .pdata_o(m_pdata),
    .pvalid_o(m_pvalid), .pready_i(pready_i), .bitcnt_o(m_bitcnt)
  );

  rff_serial_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .sin_i(sin_i),
    .sin_valid_i(sin_valid_i), .sin_ready_o(l_sin_ready), .pdata_o(l_pdata),
    .pvalid_o(l_pvalid), .pready_i(pready_i), .bitcnt_o(l_bitcnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sin_valid_i = 1'b1;
      sin_i       = b[i];
      step();
    end
    sin_valid_i = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    int exp_cnt;

    // 1: reset, then stream A5 with pready held high
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_pvalid", {31'd0, m_pvalid}, 32'd0);
    chk("rst_pdata", {24'd0, m_pdata}, 32'd0);
    chk("rst_bitcnt", {29'd0, m_bitcnt}, 32'd0);
    rst_ni = 1'b1;
    #1;
    chk("rst_sin_ready", {31'd0, m_sin_ready}, 32'd1);
    pready_i = 1'b1;
    send_byte(8'hA5);
    chk("t1_pvalid", {31'd0, m_pvalid}, 32'd1);
    chk("t1_pdata_msb", {24'd0, m_pdata}, 32'hA5);
    chk("t1_pdata_lsb", {24'd0, l_pdata}, 32'hA5);
    chk("t1_bitcnt_wrap", {29'd0, m_bitcnt}, 32'd0);
    step();
    chk("t1_drain", {31'd0, m_pvalid}, 32'd0);

    // 2: backpressure, 3C held while FF accumulates
    pready_i = 1'b0;
    send_byte(8'h3C);
    chk("t2_pvalid", {31'd0, m_pvalid}, 32'd1);
    chk("t2_pdata_msb", {24'd0, m_pdata}, 32'h3C);
    chk("t2_pdata_lsb", {24'd0, l_pdata}, 32'h3C);
    for (int i = 0; i < 7; i++) begin
      sin_valid_i = 1'b1;
      sin_i       = 1'b1;
      #1;
      chk("t2_ready_early", {31'd0, m_sin_ready}, 32'd1);
      step();
    end
    chk("t2_bitcnt7", {29'd0, m_bitcnt}, 32'd7);
    chk("t2_ready_stall", {31'd0, m_sin_ready}, 32'd0);
    step();
    chk("t2_bitcnt_stall", {29'd0, m_bitcnt}, 32'd7);
    chk("t2_pdata_hold", {24'd0, m_pdata}, 32'h3C);
    pready_i = 1'b1;
    #1;
    chk("t2_ready_release", {31'd0, m_sin_ready}, 32'd1);
    step();
    sin_valid_i = 1'b0;
    pready_i    = 1'b0;
    chk("t2_b2b_pvalid", {31'd0, m_pvalid}, 32'd1);
    chk("t2_b2b_pdata", {24'd0, m_pdata}, 32'hFF);
    chk("t2_b2b_bitcnt", {29'd0, m_bitcnt}, 32'd0);
    pready_i = 1'b1;
    step();
    chk("t2_drain", {31'd0, m_pvalid}, 32'd0);

    // 3: bit order 1,1,0,0,0,0,0,0
    send_byte(8'hC0);
    chk("t3_pdata_lsb", {24'd0, l_pdata}, 32'h03);
    chk("t3_pdata_msb", {24'd0, m_pdata}, 32'hC0);
    step();

    // 4: clr together with a 5th bit drops it and restarts the word
    pready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin_valid_i = 1'b1;
      sin_i       = 1'b1;
      step();
    end
    chk("t4_bitcnt4", {29'd0, m_bitcnt}, 32'd4);
    clr_i = 1'b1;
    step();
    clr_i       = 1'b0;
    sin_valid_i = 1'b0;
    chk("t4_clr_bitcnt", {29'd0, m_bitcnt}, 32'd0);
    chk("t4_clr_pvalid", {31'd0, m_pvalid}, 32'd0);
    w = 8'h5A;
    for (int i = 7; i >= 1; i--) begin
      sin_valid_i = 1'b1;
      sin_i       = w[i];
      step();
    end
    chk("t4_bitcnt7", {29'd0, m_bitcnt}, 32'd7);
    chk("t4_no_early", {31'd0, m_pvalid}, 32'd0);
    sin_i = w[0];
    step();
    sin_valid_i = 1'b0;
    chk("t4_pvalid", {31'd0, m_pvalid}, 32'd1);
    chk("t4_pdata", {24'd0, m_pdata}, 32'h5A);

    // 5: async reset while FULL with a partial word pending
    for (int i = 0; i < 3; i++) begin
      sin_valid_i = 1'b1;
      sin_i       = 1'b1;
      step();
    end
    sin_valid_i = 1'b0;
    chk("t5_bitcnt3", {29'd0, m_bitcnt}, 32'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t5_async_pvalid", {31'd0, m_pvalid}, 32'd0);
    chk("t5_async_pdata", {24'd0, m_pdata}, 32'd0);
    chk("t5_async_bitcnt", {29'd0, m_bitcnt}, 32'd0);
    step();
    rst_ni = 1'b1;

    // 6: gapped input, valid every other cycle, word 81
    w       = 8'h81;
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      sin_valid_i = (i % 2 == 0);
      sin_i       = (i % 2 == 0) ? w[7 - i/2] : ~w[7 - i/2];
      step();
      if (i % 2 == 0) exp_cnt = (exp_cnt + 1) % 8;
      chk("t6_bitcnt", {29'd0, m_bitcnt}, exp_cnt);
    end
    sin_valid_i = 1'b0;
    chk("t6_pvalid", {31'd0, m_pvalid}, 32'd1);
    chk("t6_pdata_msb", {24'd0, m_pdata}, 32'h81);
    chk("t6_pdata_lsb", {24'd0, l_pdata}, 32'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
